// File: rtl/mem_responder_if.sv
// Memory bus between the CPU's memory path and the responder.
interface mem_responder_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ready;
  logic              err;
  logic              busy;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ready, err, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ready, err, busy
  );
endinterface

// File: rtl/mem_responder.sv
// Word-organised memory answering the CPU bus with configurable wait states,
// a one-cycle ready pulse and an error flag for illegal addresses.
module mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 32
) (
  input  logic            clock,
  input  logic            reset,
  mem_responder_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_ready;
  logic              r_err;
  logic [31:0]       r_mem [DEPTH_WORDS];

  logic [IDX_W-1:0]  w_idx;
  logic              w_illegal;
  logic              w_access;
  logic              w_wr_en;

  assign w_idx     = r_addr[IDX_W+1:2];
  // Anything at or above 4*DEPTH_WORDS has a nonzero bit above the index field.
  assign w_illegal = (r_addr[1:0] != 2'b00) || ((r_addr >> (IDX_W + 2)) != '0);
  assign w_access  = (r_state == S_WAIT) && (r_cnt == '0);
  // Reset on the access edge suppresses the write.
  assign w_wr_en   = w_access && r_we && !w_illegal && !reset;

  assign bus.rdata = r_rdata;
  assign bus.ready = r_ready;
  assign bus.err   = r_err;
  assign bus.busy  = (r_state != S_IDLE);

  // Control FSM: capture request, count wait states, complete, acknowledge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          if (bus.req) begin
            r_we    <= bus.we;
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
            r_cnt   <= CNT_W'(WAIT_CYCLES);
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_ready <= 1'b1;
            r_err   <= w_illegal;
            if (w_illegal) begin
              r_rdata <= '0;
            end else if (!r_we) begin
              r_rdata <= r_mem[w_idx];
            end
            r_state <= S_ACK;
          end
        end
        S_ACK: begin
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Storage array write port; contents survive reset.
  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      r_mem[w_idx] <= r_wdata;
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Directed test of mem_responder: latency, decode errors, input capture,
// reset abort and back-to-back request spacing.
module tb_mem_responder;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  mem_responder_if #(.ADDR_W(32)) bus ();
  mem_responder_if #(.ADDR_W(32)) bus0 ();

  mem_responder #(
    .DEPTH_WORDS(256),
    .WAIT_CYCLES(2),
    .ADDR_W(32)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus(bus.slave)
  );

  mem_responder #(
    .DEPTH_WORDS(256),
    .WAIT_CYCLES(0),
    .ADDR_W(32)
  ) dut0 (
    .clock(clk),
    .reset(rst),
    .bus(bus0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // One transaction on the WAIT_CYCLES=2 instance, starting #1 after an edge in IDLE.
  task automatic run_txn(input logic i_we, input logic [31:0] a, input logic [31:0] d,
                         input bit scramble, output logic [31:0] rd, output logic er);
    int  n;
    bit  done;
    bus.req   = 1'b1;
    bus.we    = i_we;
    bus.addr  = a;
    bus.wdata = d;
    @(posedge clk); #1;
    bus.req = 1'b0;
    if (scramble) begin
      bus.addr  = a + 32'd4;
      bus.wdata = 32'h0;
    end
    check_eq("busy_after_e0", 32'(bus.busy), 32'd1);
    n    = 0;
    done = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      @(posedge clk); #1;
      n++;
      if (bus.ready) done = 1'b1;
    end
    check_eq("ready_latency", 32'(n), 32'd3);
    rd = bus.rdata;
    er = bus.err;
    @(posedge clk); #1;
    check_eq("ready_one_cycle", 32'(bus.ready), 32'd0);
    check_eq("idle_after_ack", 32'(bus.busy), 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  logic [31:0] mask2;
  logic [31:0] mask0;

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    rst        = 1'b1;
    bus.req    = 1'b0;
    bus.we     = 1'b0;
    bus.addr   = '0;
    bus.wdata  = '0;
    bus0.req   = 1'b0;
    bus0.we    = 1'b0;
    bus0.addr  = '0;
    bus0.wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_rdata", bus.rdata, 32'h0);
    check_eq("rst_ready", 32'(bus.ready), 32'd0);
    check_eq("rst_err", 32'(bus.err), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);

    // Basic write then read.
    run_txn(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, rd, er);
    check_eq("wr10_err", 32'(er), 32'd0);
    check_eq("wr10_rdata_unchanged", rd, 32'h0);
    run_txn(1'b0, 32'h10, 32'h0, 1'b0, rd, er);
    check_eq("rd10_data", rd, 32'hDEADBEEF);
    check_eq("rd10_err", 32'(er), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rdata_hold", bus.rdata, 32'hDEADBEEF);

    // Misaligned write.
    run_txn(1'b1, 32'h13, 32'h12345678, 1'b0, rd, er);
    check_eq("misalign_err", 32'(er), 32'd1);
    check_eq("misalign_rdata", rd, 32'h0);
    run_txn(1'b0, 32'h10, 32'h0, 1'b0, rd, er);
    check_eq("rd10_after_misalign", rd, 32'hDEADBEEF);

    // Top word and out-of-range read.
    run_txn(1'b1, 32'h3FC, 32'hCAFEF00D, 1'b0, rd, er);
    check_eq("wr3fc_err", 32'(er), 32'd0);
    run_txn(1'b0, 32'h400, 32'h0, 1'b0, rd, er);
    check_eq("oor_err", 32'(er), 32'd1);
    check_eq("oor_rdata", rd, 32'h0);
    run_txn(1'b0, 32'h3FC, 32'h0, 1'b0, rd, er);
    check_eq("rd3fc_data", rd, 32'hCAFEF00D);
    check_eq("rd3fc_err", 32'(er), 32'd0);

    // Inputs changing during WAIT must not affect the captured transaction.
    run_txn(1'b1, 32'h24, 32'h5A5A5A5A, 1'b0, rd, er);
    run_txn(1'b1, 32'h20, 32'hAAAA5555, 1'b1, rd, er);
    run_txn(1'b0, 32'h20, 32'h0, 1'b0, rd, er);
    check_eq("rd20_captured", rd, 32'hAAAA5555);
    run_txn(1'b0, 32'h24, 32'h0, 1'b0, rd, er);
    check_eq("rd24_untouched", rd, 32'h5A5A5A5A);

    // Reset on the access edge aborts the write.
    run_txn(1'b1, 32'h20, 32'h11111111, 1'b0, rd, er);
    bus.req   = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = 32'h20;
    bus.wdata = 32'h22222222;
    @(posedge clk); #1;              // E0
    bus.req = 1'b0;
    @(posedge clk); #1;              // E1
    check_eq("abort_no_ready_e1", 32'(bus.ready), 32'd0);
    @(posedge clk); #1;              // E2
    check_eq("abort_no_ready_e2", 32'(bus.ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;              // E3 = access edge, reset wins
    rst = 1'b0;
    check_eq("abort_ready", 32'(bus.ready), 32'd0);
    check_eq("abort_err", 32'(bus.err), 32'd0);
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    check_eq("abort_rdata", bus.rdata, 32'h0);
    @(posedge clk); #1;
    check_eq("abort_still_no_ready", 32'(bus.ready), 32'd0);
    run_txn(1'b0, 32'h20, 32'h0, 1'b0, rd, er);
    check_eq("rd20_after_abort", rd, 32'h11111111);

    // Held request on both instances: ready pattern over 20 edges.
    bus.req   = 1'b1;
    bus.we    = 1'b0;
    bus.addr  = 32'h10;
    bus0.req  = 1'b1;
    bus0.we   = 1'b0;
    bus0.addr = 32'h0;
    mask2 = '0;
    mask0 = '0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      mask2[k] = bus.ready;
      mask0[k] = bus0.ready;
    end
    bus.req  = 1'b0;
    bus0.req = 1'b0;
    check_eq("held_req_wait2", mask2, 32'h00042108);
    check_eq("held_req_wait0", mask0, 32'h00092492);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
